// File: rtl/sdframe_addr_gen.sv
// sdframe_addr_gen: frame-address generator and write/read burst arbiter.
// Tracks one linear word address per side inside the bank chosen by the
// ping-pong switcher. It issues one-burst requests to the SDRAM command
// controller and reports when a whole frame has been written or read.
module sdframe_addr_gen #(
  parameter int ADDR_W      = 22,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_AW     = 10,
  parameter int RD_THRESH   = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_load,
  input  logic                rd_load,
  input  logic [1:0]          wr_bank,
  input  logic [1:0]          rd_bank,
  input  logic [FIFO_AW-1:0]  wr_fifo_usedw,
  input  logic [FIFO_AW-1:0]  rd_fifo_usedw,
  input  logic                sdr_wr_ack,
  input  logic                sdr_rd_ack,
  output logic                sdr_wr_req,
  output logic                sdr_rd_req,
  output logic [ADDR_W+1:0]   sdr_wr_addr,
  output logic [ADDR_W+1:0]   sdr_rd_addr,
  output logic                frame_write_done,
  output logic                frame_read_done
);

  localparam logic [ADDR_W-1:0]  BURST_INC = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]  FRAME_END = ADDR_W'(FRAME_WORDS);
  localparam logic [FIFO_AW:0]   WR_LEVEL  = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [FIFO_AW:0]   RD_LEVEL  = (FIFO_AW+1)'(RD_THRESH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } state_t;

  typedef enum logic {
    SERVED_WR = 1'b0,
    SERVED_RD = 1'b1
  } side_t;

  // Registered state
  state_t              fsm_q,          fsm_d;
  side_t               last_served_q,  last_served_d;
  logic [ADDR_W-1:0]   wr_addr_q,      wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q,      rd_addr_d;
  logic [1:0]          wr_bank_q,      wr_bank_d;
  logic [1:0]          rd_bank_q,      rd_bank_d;
  logic [1:0]          wr_pend_bank_q, wr_pend_bank_d;
  logic [1:0]          rd_pend_bank_q, rd_pend_bank_d;
  logic                wr_active_q,    wr_active_d;
  logic                rd_active_q,    rd_active_d;
  logic                wr_load_pend_q, wr_load_pend_d;
  logic                rd_load_pend_q, rd_load_pend_d;
  logic                wr_done_q,      wr_done_d;
  logic                rd_done_q,      rd_done_d;
  logic                wr_req_q,       wr_req_d;
  logic                rd_req_q,       rd_req_d;
  logic [ADDR_W+1:0]   wr_out_addr_q,  wr_out_addr_d;
  logic [ADDR_W+1:0]   rd_out_addr_q,  rd_out_addr_d;

  // Combinational helpers
  logic                wr_in_burst_s;
  logic                rd_in_burst_s;
  logic                wr_ack_s;
  logic                rd_ack_s;
  logic                wr_ready_s;
  logic                rd_ready_s;
  logic [ADDR_W-1:0]   wr_addr_inc_s;
  logic [ADDR_W-1:0]   rd_addr_inc_s;

  // Burst-state decode, acks qualified by the matching burst, and readiness.
  // A load pulse in the same cycle blocks burst entry so a burst never
  // starts with an address that is being restarted on that very edge.
  always_comb begin
    wr_in_burst_s = (fsm_q == ST_WR_BURST);
    rd_in_burst_s = (fsm_q == ST_RD_BURST);
    wr_ack_s      = wr_in_burst_s & sdr_wr_ack;
    rd_ack_s      = rd_in_burst_s & sdr_rd_ack;
    wr_addr_inc_s = wr_addr_q + BURST_INC;
    rd_addr_inc_s = rd_addr_q + BURST_INC;
    wr_ready_s    = wr_active_q & ({1'b0, wr_fifo_usedw} >= WR_LEVEL)
                    & ~wr_load_pend_q & ~wr_load;
    rd_ready_s    = rd_active_q & ({1'b0, rd_fifo_usedw} < RD_LEVEL)
                    & ~rd_load_pend_q & ~rd_load;
  end

  // Write-side address/bank/done bookkeeping: loads, deferred loads, increments.
  always_comb begin
    wr_addr_d      = wr_addr_q;
    wr_bank_d      = wr_bank_q;
    wr_pend_bank_d = wr_pend_bank_q;
    wr_active_d    = wr_active_q;
    wr_load_pend_d = wr_load_pend_q;
    wr_done_d      = wr_done_q;
    if (wr_load && (!wr_in_burst_s || sdr_wr_ack)) begin
      // Immediate load; also wins over a coincident ack
      wr_bank_d      = wr_bank;
      wr_addr_d      = '0;
      wr_done_d      = 1'b0;
      wr_active_d    = 1'b1;
      wr_load_pend_d = 1'b0;
    end else if (wr_load) begin
      // Mid-burst load: hold it until the burst completes
      wr_load_pend_d = 1'b1;
      wr_pend_bank_d = wr_bank;
    end else if (wr_ack_s && wr_load_pend_q) begin
      wr_bank_d      = wr_pend_bank_q;
      wr_addr_d      = '0;
      wr_done_d      = 1'b0;
      wr_active_d    = 1'b1;
      wr_load_pend_d = 1'b0;
    end else if (wr_ack_s) begin
      if (wr_addr_inc_s == FRAME_END) begin
        wr_addr_d = '0;
        wr_done_d = 1'b1;
      end else begin
        wr_addr_d = wr_addr_inc_s;
      end
    end else begin
      wr_addr_d = wr_addr_q;
    end
  end

  // Read-side address/bank/done bookkeeping, mirroring the write side.
  always_comb begin
    rd_addr_d      = rd_addr_q;
    rd_bank_d      = rd_bank_q;
    rd_pend_bank_d = rd_pend_bank_q;
    rd_active_d    = rd_active_q;
    rd_load_pend_d = rd_load_pend_q;
    rd_done_d      = rd_done_q;
    if (rd_load && (!rd_in_burst_s || sdr_rd_ack)) begin
      rd_bank_d      = rd_bank;
      rd_addr_d      = '0;
      rd_done_d      = 1'b0;
      rd_active_d    = 1'b1;
      rd_load_pend_d = 1'b0;
    end else if (rd_load) begin
      rd_load_pend_d = 1'b1;
      rd_pend_bank_d = rd_bank;
    end else if (rd_ack_s && rd_load_pend_q) begin
      rd_bank_d      = rd_pend_bank_q;
      rd_addr_d      = '0;
      rd_done_d      = 1'b0;
      rd_active_d    = 1'b1;
      rd_load_pend_d = 1'b0;
    end else if (rd_ack_s) begin
      if (rd_addr_inc_s == FRAME_END) begin
        rd_addr_d = '0;
        rd_done_d = 1'b1;
      end else begin
        rd_addr_d = rd_addr_inc_s;
      end
    end else begin
      rd_addr_d = rd_addr_q;
    end
  end

  // Arbiter FSM: alternates sides when both are ready, holds req until ack.
  always_comb begin
    fsm_d         = fsm_q;
    last_served_d = last_served_q;
    wr_req_d      = wr_req_q;
    rd_req_d      = rd_req_q;
    wr_out_addr_d = wr_out_addr_q;
    rd_out_addr_d = rd_out_addr_q;
    case (fsm_q)
      ST_IDLE: begin
        if (wr_ready_s && (!rd_ready_s || (last_served_q == SERVED_RD))) begin
          fsm_d         = ST_WR_BURST;
          wr_req_d      = 1'b1;
          wr_out_addr_d = {wr_bank_q, wr_addr_q};
          last_served_d = SERVED_WR;
        end else if (rd_ready_s) begin
          fsm_d         = ST_RD_BURST;
          rd_req_d      = 1'b1;
          rd_out_addr_d = {rd_bank_q, rd_addr_q};
          last_served_d = SERVED_RD;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        if (sdr_wr_ack) begin
          wr_req_d = 1'b0;
          fsm_d    = ST_IDLE;
        end else begin
          wr_req_d = 1'b1;
        end
      end
      ST_RD_BURST: begin
        if (sdr_rd_ack) begin
          rd_req_d = 1'b0;
          fsm_d    = ST_IDLE;
        end else begin
          rd_req_d = 1'b1;
        end
      end
      default: begin
        fsm_d    = ST_IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q          <= ST_IDLE;
      last_served_q  <= SERVED_RD;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      wr_bank_q      <= 2'd0;
      rd_bank_q      <= 2'd0;
      wr_pend_bank_q <= 2'd0;
      rd_pend_bank_q <= 2'd0;
      wr_active_q    <= 1'b0;
      rd_active_q    <= 1'b0;
      wr_load_pend_q <= 1'b0;
      rd_load_pend_q <= 1'b0;
      wr_done_q      <= 1'b0;
      rd_done_q      <= 1'b0;
      wr_req_q       <= 1'b0;
      rd_req_q       <= 1'b0;
      wr_out_addr_q  <= '0;
      rd_out_addr_q  <= '0;
    end else begin
      fsm_q          <= fsm_d;
      last_served_q  <= last_served_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_pend_bank_q <= wr_pend_bank_d;
      rd_pend_bank_q <= rd_pend_bank_d;
      wr_active_q    <= wr_active_d;
      rd_active_q    <= rd_active_d;
      wr_load_pend_q <= wr_load_pend_d;
      rd_load_pend_q <= rd_load_pend_d;
      wr_done_q      <= wr_done_d;
      rd_done_q      <= rd_done_d;
      wr_req_q       <= wr_req_d;
      rd_req_q       <= rd_req_d;
      wr_out_addr_q  <= wr_out_addr_d;
      rd_out_addr_q  <= rd_out_addr_d;
    end
  end

  assign sdr_wr_req       = wr_req_q;
  assign sdr_rd_req       = rd_req_q;
  assign sdr_wr_addr      = wr_out_addr_q;
  assign sdr_rd_addr      = rd_out_addr_q;
  assign frame_write_done = wr_done_q;
  assign frame_read_done  = rd_done_q;

endmodule

// File: tb/tb_sdframe_addr_gen.sv
// Directed self-checking bench for sdframe_addr_gen.
module tb_sdframe_addr_gen;

  logic        clk;
  logic        rst_n;
  logic        wr_load, rd_load;
  logic [1:0]  wr_bank, rd_bank;
  logic [9:0]  wr_fifo_usedw, rd_fifo_usedw;
  logic        sdr_wr_ack, sdr_rd_ack;
  logic        sdr_wr_req, sdr_rd_req;
  logic [23:0] sdr_wr_addr, sdr_rd_addr;
  logic        frame_write_done, frame_read_done;

  int checks;
  int failures;

  sdframe_addr_gen dut (
    .clk(clk), .rst_n(rst_n),
    .wr_load(wr_load), .rd_load(rd_load),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .wr_fifo_usedw(wr_fifo_usedw), .rd_fifo_usedw(rd_fifo_usedw),
    .sdr_wr_ack(sdr_wr_ack), .sdr_rd_ack(sdr_rd_ack),
    .sdr_wr_req(sdr_wr_req), .sdr_rd_req(sdr_rd_req),
    .sdr_wr_addr(sdr_wr_addr), .sdr_rd_addr(sdr_rd_addr),
    .frame_write_done(frame_write_done), .frame_read_done(frame_read_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    wr_load = 1'b0; rd_load = 1'b0; wr_bank = 2'd0; rd_bank = 2'd0;
    wr_fifo_usedw = 10'd0; rd_fifo_usedw = 10'd300;
    sdr_wr_ack = 1'b0; sdr_rd_ack = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) until the selected request is high.
  task automatic wait_req(input bit is_wr, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (is_wr ? sdr_wr_req : sdr_rd_req) got = 1'b1;
    end
  endtask

  task automatic pulse_wr_ack();
    sdr_wr_ack = 1'b1; tick(); sdr_wr_ack = 1'b0;
  endtask

  task automatic pulse_rd_ack();
    sdr_rd_ack = 1'b1; tick(); sdr_rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({sdr_wr_req, sdr_rd_req, frame_write_done, frame_read_done} !== 4'b0000 ||
        sdr_wr_addr !== 24'h0 || sdr_rd_addr !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b%b done=%b%b wa=%h ra=%h want all zero",
               sdr_wr_req, sdr_rd_req, frame_write_done, frame_read_done, sdr_wr_addr, sdr_rd_addr);
    end
    tick(); tick();
    checks++;
    if (sdr_wr_req !== 1'b0 || sdr_rd_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_req got wr=%b rd=%b want 0 0", sdr_wr_req, sdr_rd_req);
    end
  endtask

  task automatic test_basic_write();
    apply_reset();
    wr_bank = 2'd0; wr_fifo_usedw = 10'd256;
    wr_load = 1'b1; tick(); wr_load = 1'b0;
    checks++;
    if (sdr_wr_req !== 1'b0) begin
      failures++; $display("FAIL basic_req_early got=%b want=0", sdr_wr_req);
    end
    tick();
    checks++;
    if (sdr_wr_req !== 1'b1 || sdr_wr_addr !== 24'h000000) begin
      failures++; $display("FAIL basic_first got req=%b addr=%h want 1 000000", sdr_wr_req, sdr_wr_addr);
    end
    pulse_wr_ack();
    checks++;
    if (sdr_wr_req !== 1'b0) begin
      failures++; $display("FAIL basic_req_drop got=%b want=0", sdr_wr_req);
    end
    tick();
    checks++;
    if (sdr_wr_req !== 1'b1 || sdr_wr_addr !== 24'h000100) begin
      failures++; $display("FAIL basic_second got req=%b addr=%h want 1 000100", sdr_wr_req, sdr_wr_addr);
    end
    pulse_wr_ack();
  endtask

  task automatic test_alternate();
    bit [1:0]    got_side;
    logic [23:0] exp_addr;
    apply_reset();
    wr_bank = 2'd1; rd_bank = 2'd2;
    wr_fifo_usedw = 10'd300; rd_fifo_usedw = 10'd0;
    wr_load = 1'b1; rd_load = 1'b1; tick(); wr_load = 1'b0; rd_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got_side = 2'b00;
      for (int c = 0; c < 20 && got_side == 2'b00; c++) begin
        tick();
        got_side = {sdr_wr_req, sdr_rd_req};
      end
      checks++;
      if (got_side !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL alt_order burst=%0d got wr/rd=%b want=%b", k, got_side,
                             (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      exp_addr = (k % 2 == 0) ? {2'd1, 22'(k / 2 * 256)} : {2'd2, 22'(k / 2 * 256)};
      checks++;
      if (((k % 2 == 0) ? sdr_wr_addr : sdr_rd_addr) !== exp_addr) begin
        failures++; $display("FAIL alt_addr burst=%0d got=%h want=%h", k,
                             (k % 2 == 0) ? sdr_wr_addr : sdr_rd_addr, exp_addr);
      end
      if (k % 2 == 0) pulse_wr_ack(); else pulse_rd_ack();
    end
  endtask

  task automatic test_frame_wrap_and_load();
    bit          got;
    logic [23:0] exp_addr;
    int          addr_bad;
    apply_reset();
    wr_bank = 2'd2; wr_fifo_usedw = 10'd256;
    wr_load = 1'b1; tick(); wr_load = 1'b0;
    addr_bad = 0;
    for (int i = 0; i < 1200; i++) begin
      wait_req(1'b1, 10, got);
      exp_addr = {2'd2, 22'(i * 256)};
      if (!got || sdr_wr_addr !== exp_addr || frame_write_done !== 1'b0) begin
        if (addr_bad == 0)
          $display("FAIL wrap_walk burst=%0d got req=%b addr=%h done=%b want 1 %h 0",
                   i, got, sdr_wr_addr, frame_write_done, exp_addr);
        addr_bad++;
      end
      pulse_wr_ack();
    end
    checks++;
    if (addr_bad != 0) failures++;
    checks++;
    if (frame_write_done !== 1'b1) begin
      failures++; $display("FAIL wrap_done got=%b want=1", frame_write_done);
    end
    wait_req(1'b1, 10, got);
    checks++;
    if (!got || sdr_wr_addr !== 24'h800000 || frame_write_done !== 1'b1) begin
      failures++; $display("FAIL wrap_1201 got req=%b addr=%h done=%b want 1 800000 1",
                           got, sdr_wr_addr, frame_write_done);
    end
    pulse_wr_ack();
    // Next burst at 0x100; a bank-3 load arrives mid-burst
    wait_req(1'b1, 10, got);
    wr_bank = 2'd3; wr_load = 1'b1; tick(); wr_load = 1'b0;
    tick();
    checks++;
    if (sdr_wr_req !== 1'b1 || sdr_wr_addr !== 24'h800100 || frame_write_done !== 1'b1) begin
      failures++; $display("FAIL pend_hold got req=%b addr=%h done=%b want 1 800100 1",
                           sdr_wr_req, sdr_wr_addr, frame_write_done);
    end
    pulse_wr_ack();
    checks++;
    if (frame_write_done !== 1'b0 || sdr_wr_req !== 1'b0) begin
      failures++; $display("FAIL pend_apply got done=%b req=%b want 0 0", frame_write_done, sdr_wr_req);
    end
    wait_req(1'b1, 10, got);
    checks++;
    if (!got || sdr_wr_addr !== 24'hC00000) begin
      failures++; $display("FAIL pend_next got req=%b addr=%h want 1 C00000", got, sdr_wr_addr);
    end
    // Ack and load on the same edge: load wins
    sdr_wr_ack = 1'b1; wr_load = 1'b1; tick(); sdr_wr_ack = 1'b0; wr_load = 1'b0;
    wait_req(1'b1, 10, got);
    checks++;
    if (!got || sdr_wr_addr !== 24'hC00000) begin
      failures++; $display("FAIL ack_load_same got req=%b addr=%h want 1 C00000", got, sdr_wr_addr);
    end
    pulse_wr_ack();
  endtask

  task automatic test_rd_threshold_and_reset();
    bit got;
    apply_reset();
    rd_bank = 2'd1; rd_fifo_usedw = 10'd256; wr_fifo_usedw = 10'd300;
    rd_load = 1'b1; tick(); rd_load = 1'b0;
    wait_req(1'b0, 5, got);
    checks++;
    if (got !== 1'b0) begin
      failures++; $display("FAIL rd_at_thresh got req=%b want=0", got);
    end
    rd_fifo_usedw = 10'd255;
    tick(); tick();
    checks++;
    if (sdr_rd_req !== 1'b1 || sdr_rd_addr !== 24'h400000) begin
      failures++; $display("FAIL rd_below got req=%b addr=%h want 1 400000", sdr_rd_req, sdr_rd_addr);
    end
    pulse_wr_ack();
    checks++;
    if (sdr_rd_req !== 1'b1) begin
      failures++; $display("FAIL stray_ack got rd_req=%b want=1", sdr_rd_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sdr_rd_req !== 1'b0) begin
      failures++; $display("FAIL async_reset got rd_req=%b want=0", sdr_rd_req);
    end
    tick();
    rst_n = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (sdr_rd_req || sdr_wr_req) got = 1'b1;
    end
    checks++;
    if (got !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got any_req=%b want=0", got);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_write();
    test_alternate();
    test_frame_wrap_and_load();
    test_rd_threshold_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
